// File: rtl/fs_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares the fast-serial TX byte channel among NUM_REQ streams.
// Define FS_TX_ARB_STATS_EN to add per-requester packet counters and an eviction counter.
module fs_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned HOLDOFF      = 2,
  parameter int unsigned IDLE_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_REQ-1:0]    i_req_valid,
  input  logic [8*NUM_REQ-1:0]  i_req_data,
  input  logic [NUM_REQ-1:0]    i_req_last,
  output logic [NUM_REQ-1:0]    o_req_ready,
  output logic [7:0]            o_tx_data,
  output logic                  o_tx_write,
  input  logic                  i_tx_busy,
  output logic [NUM_REQ-1:0]    o_grant,
`ifdef FS_TX_ARB_STATS_EN
  output logic [16*NUM_REQ-1:0] o_pkt_count,
  output logic [15:0]           o_evict_count,
`endif
  output logic                  o_timeout
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned HO_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int unsigned TO_W  = $clog2(IDLE_TIMEOUT + 1);

  typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [HO_W-1:0]      holdoff_q, holdoff_d;
  logic [TO_W-1:0]      stall_q, stall_d;
  logic                 tx_write_q, tx_write_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 timeout_q, timeout_d;

  logic                 own_valid, own_last;
  logic [7:0]           own_data;
  logic                 accept_ok, xfer;
  logic                 pick_found, hi_found;
  logic [PTR_W-1:0]     pick_idx, hi_idx, lo_idx, owner_next;

  // Owner's request lines
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (owner_q == PTR_W'(k)) begin
        own_valid = i_req_valid[k];
        own_last  = i_req_last[k];
        own_data  = i_req_data[8*k +: 8];
      end
    end
  end

  // Round-robin pick: lowest valid index at or above the pointer, else lowest valid overall
  always_comb begin
    hi_found = 1'b0;
    pick_found = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        pick_found = 1'b1;
        lo_idx = PTR_W'(i);
        if (PTR_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx = PTR_W'(i);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  assign owner_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + PTR_W'(1);
  assign accept_ok  = (holdoff_q == '0) && !i_tx_busy;
  assign xfer       = (state_q == ST_SEND) && own_valid && accept_ok;
  assign o_req_ready = ((state_q == ST_SEND) && accept_ok) ? grant_q : '0;

  // Next-state and registered output logic
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    owner_d    = owner_q;
    ptr_d      = ptr_q;
    stall_d    = stall_q;
    tx_write_d = 1'b0;
    tx_data_d  = tx_data_q;
    timeout_d  = 1'b0;
    holdoff_d  = (holdoff_q != '0) ? holdoff_q - HO_W'(1) : '0;

    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          tx_write_d = 1'b1;
          tx_data_d  = own_data;
          holdoff_d  = HO_W'(HOLDOFF);
          stall_d    = '0;
          if (own_last) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = owner_next;
          end
        end else if (own_valid) begin
          stall_d = '0;
        end else if (stall_q == TO_W'(IDLE_TIMEOUT - 1)) begin
          // Owner stalled mid-packet too long: abandon the packet
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          grant_d   = '0;
          ptr_d     = owner_next;
          stall_d   = '0;
        end else begin
          stall_d = stall_q + TO_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      owner_q    <= '0;
      ptr_q      <= '0;
      holdoff_q  <= '0;
      stall_q    <= '0;
      tx_write_q <= 1'b0;
      tx_data_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      holdoff_q  <= holdoff_d;
      stall_q    <= stall_d;
      tx_write_q <= tx_write_d;
      tx_data_q  <= tx_data_d;
      timeout_q  <= timeout_d;
    end
  end

  assign o_grant    = grant_q;
  assign o_tx_write = tx_write_q;
  assign o_tx_data  = tx_data_q;
  assign o_timeout  = timeout_q;

`ifdef FS_TX_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0]              evict_cnt_q, evict_cnt_d;

  // Completed-packet and eviction counters, wrapping at 16 bits
  always_comb begin
    pkt_cnt_d   = pkt_cnt_q;
    evict_cnt_d = evict_cnt_q;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (xfer && own_last && (owner_q == PTR_W'(k))) begin
        pkt_cnt_d[k] = pkt_cnt_q[k] + 16'd1;
      end
    end
    if (timeout_d) begin
      evict_cnt_d = evict_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pkt_cnt_q   <= '0;
      evict_cnt_q <= '0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      evict_cnt_q <= evict_cnt_d;
    end
  end

  assign o_pkt_count   = pkt_cnt_q;
  assign o_evict_count = evict_cnt_q;
`endif

endmodule

// File: tb/tb_fs_tx_arbiter.sv
// Self-checking bench for fs_tx_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Stats ports are connected and checked when FS_TX_ARB_STATS_EN is defined.
module tb_fs_tx_arbiter;

  localparam int NR   = 3;
  localparam int HO   = 2;
  localparam int TO   = 16;
  localparam int MAXC = 8192;
  localparam int QD   = 4096;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_valid;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [7:0]        tx_data;
  logic              tx_write;
  logic              tx_busy = 1'b0;
  logic [NR-1:0]     grant;
  logic              timeout;
`ifdef FS_TX_ARB_STATS_EN
  logic [16*NR-1:0]  pkt_count;
  logic [15:0]       evict_count;
`endif

  fs_tx_arbiter #(.NUM_REQ(NR), .HOLDOFF(HO), .IDLE_TIMEOUT(TO)) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .i_req_last(req_last),
    .o_req_ready(req_ready),
    .o_tx_data(tx_data),
    .o_tx_write(tx_write),
    .i_tx_busy(tx_busy),
    .o_grant(grant),
`ifdef FS_TX_ARB_STATS_EN
    .o_pkt_count(pkt_count),
    .o_evict_count(evict_count),
`endif
    .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  // Requester-side stimulus: per-requester byte queues and per-cycle presentation
  logic       v_valid [NR];
  logic [7:0] v_data  [NR];
  logic       v_last  [NR];
  logic [8:0] pbuf [NR][QD];
  int         head [NR];
  int         tail [NR];
  logic       acc  [NR];
  int         pct  [NR];
  int         busy_pct = 0;
  logic       busy_force = 1'b0;
  int         cyc = 0;

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      req_valid[k]       = v_valid[k];
      req_data[8*k +: 8] = v_data[k];
      req_last[k]        = v_last[k];
    end
  end

  int         n_checks = 0;
  int         n_fail = 0;
  int         s_cyc[$];
  logic [7:0] s_dat[$];
  logic [NR-1:0] gr_log [MAXC];
  logic          to_log [MAXC];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d, t=%0t)", nm, act, exp, cyc, $time);
    end
  endtask

  // Behavioural model: owner index (-1 when idle), RR pointer, holdoff and stall counts as plain integers
  int         m_owner = -1;
  int         m_ptr = 0;
  int         m_hold = 0;
  int         m_stall = 0;
  logic       m_write = 1'b0;
  logic [7:0] m_data = 8'h00;
  logic       m_timeout = 1'b0;
  logic [15:0] m_pkt [NR];
  logic [15:0] m_evict = 16'h0;
  bit         m_can;
  bit         m_found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_stall = 0;
      m_write = 1'b0; m_data = 8'h00; m_timeout = 1'b0; m_evict = 16'h0;
      for (int k = 0; k < NR; k++) m_pkt[k] = 16'h0;
    end else begin
      m_can = (m_owner >= 0) && (m_hold == 0) && !tx_busy;
      m_write = 1'b0;
      m_timeout = 1'b0;
      if (m_hold > 0) m_hold = m_hold - 1;
      if (m_owner < 0) begin
        m_found = 0;
        m_stall = 0;
        for (int off = 0; off < NR; off++) begin
          if (!m_found && v_valid[(m_ptr + off) % NR]) begin
            m_found = 1;
            m_owner = (m_ptr + off) % NR;
          end
        end
      end else if (v_valid[m_owner] && m_can) begin
        m_write = 1'b1;
        m_data = v_data[m_owner];
        m_hold = HO;
        m_stall = 0;
        if (v_last[m_owner]) begin
          m_pkt[m_owner] = m_pkt[m_owner] + 16'd1;
          m_ptr = (m_owner + 1) % NR;
          m_owner = -1;
        end
      end else if (v_valid[m_owner]) begin
        m_stall = 0;
      end else begin
        m_stall = m_stall + 1;
        if (m_stall == TO) begin
          m_timeout = 1'b1;
          m_evict = m_evict + 16'd1;
          m_ptr = (m_owner + 1) % NR;
          m_owner = -1;
          m_stall = 0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    int eg;
    int er;
    #1;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    er = ((m_owner >= 0) && (m_hold == 0) && !tx_busy) ? eg : 0;
    check("grant", int'(grant), eg);
    check("ready", int'(req_ready), er);
    check("tx_write", int'(tx_write), int'(m_write));
    check("tx_data", int'(tx_data), int'(m_data));
    check("timeout", int'(timeout), int'(m_timeout));
`ifdef FS_TX_ARB_STATS_EN
    for (int k = 0; k < NR; k++) check("pkt_count", int'(pkt_count[16*k +: 16]), int'(m_pkt[k]));
    check("evict_count", int'(evict_count), int'(m_evict));
`endif
  end

  task automatic enq(input int k, input logic [7:0] b, input logic last);
    pbuf[k][tail[k]] = {last, b};
    tail[k]++;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    for (int k = 0; k < NR; k++) if (acc[k]) head[k]++;
    tx_busy = busy_force || ((busy_pct > 0) && ($urandom_range(99) < busy_pct));
    for (int k = 0; k < NR; k++) begin
      if ((head[k] < tail[k]) && ($urandom_range(99) < pct[k])) begin
        v_valid[k] = 1'b1;
        v_data[k]  = pbuf[k][head[k]][7:0];
        v_last[k]  = pbuf[k][head[k]][8];
      end else begin
        v_valid[k] = 1'b0;
        v_data[k]  = 8'($urandom);
        v_last[k]  = 1'($urandom);
      end
    end
    #2;
    for (int k = 0; k < NR; k++) acc[k] = v_valid[k] && req_ready[k];
    if (cyc < MAXC) begin
      gr_log[cyc] = grant;
      to_log[cyc] = timeout;
    end
    if (tx_write) begin
      s_cyc.push_back(cyc);
      s_dat.push_back(tx_data);
    end
  endtask

  function automatic bit pending();
    bit p = (m_owner >= 0);
    for (int k = 0; k < NR; k++) if (head[k] + (acc[k] ? 1 : 0) < tail[k]) p = 1;
    return p;
  endfunction

  task automatic drain(input int maxc, input string nm);
    int n = 0;
    while (pending() && n < maxc) begin
      cycle();
      n++;
    end
    check({nm, "_drain_done"}, pending() ? 1 : 0, 0);
    repeat (HO + 2) cycle();
  endtask

  task automatic wait_strobe(input int base, input int maxc, input string nm);
    int n = 0;
    while (s_cyc.size() <= base && n < maxc) begin
      cycle();
      n++;
    end
    check({nm, "_strobe_seen"}, (s_cyc.size() > base) ? 1 : 0, 1);
  endtask

  function automatic int sd(input int i);
    return (i < s_dat.size()) ? int'(s_dat[i]) : -1;
  endfunction

  function automatic int sc(input int i);
    return (i < s_cyc.size()) ? s_cyc[i] : -1000;
  endfunction

  function automatic int gl(input int t);
    return (t >= 0 && t < MAXC) ? int'(gr_log[t]) : -1;
  endfunction

  initial begin
    int base;
    int c0;
    int fall;
    int tcyc;
    for (int k = 0; k < NR; k++) begin
      v_valid[k] = 1'b0; v_data[k] = 8'h00; v_last[k] = 1'b0;
      head[k] = 0; tail[k] = 0; acc[k] = 1'b0; pct[k] = 100;
      m_pkt[k] = 16'h0;
    end

    // Reset state
    repeat (3) cycle();
    check("rst_grant", int'(grant), 0);
    check("rst_ready", int'(req_ready), 0);
    check("rst_write", int'(tx_write), 0);
    check("rst_data", int'(tx_data), 0);
    check("rst_timeout", int'(timeout), 0);
    rst_n = 1'b1;
    repeat (2) cycle();

    // Contention from pointer 0: req0 packet completes before req1's
    base = s_cyc.size();
    enq(0, 8'hA0, 1'b0); enq(0, 8'hA1, 1'b1);
    enq(1, 8'hB0, 1'b0); enq(1, 8'hB1, 1'b1);
    drain(200, "cont");
    check("cont_count", s_cyc.size() - base, 4);
    check("cont_b0", sd(base), 8'hA0);
    check("cont_b1", sd(base + 1), 8'hA1);
    check("cont_b2", sd(base + 2), 8'hB0);
    check("cont_b3", sd(base + 3), 8'hB1);

    // Second simultaneous request: pointer wraps past req1 back to req0
    base = s_cyc.size();
    enq(0, 8'hC0, 1'b1); enq(1, 8'hD0, 1'b1);
    drain(200, "wrap");
    check("wrap_b0", sd(base), 8'hC0);
    check("wrap_b1", sd(base + 1), 8'hD0);

    // Single packet, busy low: strobes exactly HOLDOFF+1 apart, grant released afterwards
    base = s_cyc.size();
    enq(0, 8'h11, 1'b0); enq(0, 8'h22, 1'b0); enq(0, 8'h33, 1'b1);
    drain(200, "single");
    check("single_count", s_cyc.size() - base, 3);
    check("single_b0", sd(base), 8'h11);
    check("single_b1", sd(base + 1), 8'h22);
    check("single_b2", sd(base + 2), 8'h33);
    check("single_gap0", sc(base + 1) - sc(base), 3);
    check("single_gap1", sc(base + 2) - sc(base + 1), 3);
    check("single_grant_mid", gl(sc(base + 1)), 1);
    check("single_grant_end", int'(grant), 0);

    // Busy back-pressure for 40 cycles after the first strobe
    base = s_cyc.size();
    enq(0, 8'h41, 1'b0); enq(0, 8'h42, 1'b0); enq(0, 8'h43, 1'b1);
    wait_strobe(base, 50, "busy");
    busy_force = 1'b1;
    repeat (40) cycle();
    busy_force = 1'b0;
    fall = cyc + 1;
    drain(200, "busy");
    check("busy_count", s_cyc.size() - base, 3);
    check("busy_b1", sd(base + 1), 8'h42);
    check("busy_b2", sd(base + 2), 8'h43);
    check("busy_resume_cycle", sc(base + 1), fall + 1);

    // Timeout: req1 stalls mid-packet, pending req0 is granted after eviction
    base = s_cyc.size();
    enq(1, 8'h5A, 1'b0);
    wait_strobe(base, 50, "tmo");
    c0 = sc(base);
    enq(0, 8'h66, 1'b1);
    tcyc = -1;
    for (int n = 0; n < 40 && tcyc < 0; n++) begin
      cycle();
      if (timeout) tcyc = cyc;
    end
    check("tmo_seen", (tcyc >= 0) ? 1 : 0, 1);
    check("tmo_latency", tcyc - c0, TO);
    drain(200, "tmo");
    check("tmo_grant_at_pulse", gl(tcyc), 0);
    check("tmo_grant_next", gl(tcyc + 1), 1);
    check("tmo_count", s_cyc.size() - base, 2);
    check("tmo_next_byte", sd(base + 1), 8'h66);

    // Reset during a strobe cycle, then arbitration restarts from pointer 0
    base = s_cyc.size();
    enq(0, 8'h71, 1'b0); enq(0, 8'h72, 1'b0); enq(0, 8'h73, 1'b1);
    wait_strobe(base, 50, "rstmid");
    rst_n = 1'b0;
    #1;
    check("rstmid_write", int'(tx_write), 0);
    check("rstmid_grant", int'(grant), 0);
    check("rstmid_ready", int'(req_ready), 0);
    for (int k = 0; k < NR; k++) begin
      head[k] = tail[k];
      acc[k] = 1'b0;
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    base = s_cyc.size();
    enq(1, 8'h81, 1'b1); enq(0, 8'h91, 1'b1);
    drain(200, "rstmid");
    check("rstmid_first", sd(base), 8'h91);
    check("rstmid_second", sd(base + 1), 8'h81);

    // Randomized traffic with varying valid duty and busy back-pressure
    busy_pct = 15;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) begin
        for (int k = 0; k < NR; k++) begin
          case ($urandom_range(2))
            0: pct[k] = 100;
            1: pct[k] = 70;
            default: pct[k] = 2;
          endcase
        end
      end
      for (int k = 0; k < NR; k++) begin
        if ((tail[k] - head[k] < 3) && ($urandom_range(3) == 0) && (tail[k] + 4 < QD)) begin
          int len;
          len = int'($urandom_range(4, 1));
          for (int j = 0; j < len; j++) enq(k, 8'($urandom), (j == len - 1) ? 1'b1 : 1'b0);
        end
      end
      cycle();
    end
    busy_pct = 0;
    for (int k = 0; k < NR; k++) pct[k] = 100;
    drain(2000, "rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
